// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: byte FIFO feeding an SPI framing/shift stage.
// Define SPI_FRAME_LSB_FIRST_EN to shift LSB first.
module spi_frame_ctrl #(
  parameter int DEPTH = 4,
  parameter int BITS  = 8,
  parameter int GAP   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_data,
  input  logic            wr_last,
  output logic            full,
  output logic            empty,
  output logic            busy,
  output logic            ss,
  output logic            sdo,
  input  logic            sdi,
  output logic            rx_valid,
  output logic [BITS-1:0] rx_data,
  output logic            ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BITS);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    STALL,
    GAP_HI
  } state_t;

`ifdef SPI_FRAME_LSB_FIRST_EN
  function automatic logic first_bit(
    input logic [BITS-1:0] d
  );
    return d[0];
  endfunction

  function automatic logic [BITS-1:0] tx_adv(
    input logic [BITS-1:0] d
  );
    return d >> 1;
  endfunction

  function automatic logic [BITS-1:0] rx_ins(
    input logic [BITS-1:0] r,
    input logic            b
  );
    return {b, r[BITS-1:1]};
  endfunction
`else
  function automatic logic first_bit(
    input logic [BITS-1:0] d
  );
    return d[BITS-1];
  endfunction

  function automatic logic [BITS-1:0] tx_adv(
    input logic [BITS-1:0] d
  );
    return d << 1;
  endfunction

  function automatic logic [BITS-1:0] rx_ins(
    input logic [BITS-1:0] r,
    input logic            b
  );
    return {r[BITS-2:0], b};
  endfunction
`endif

  logic [BITS:0]   mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [AW:0]     cnt;
  logic            push;
  logic            pop;
  logic [BITS:0]   head;
  logic [BITS-1:0] head_data;

  assign full      = cnt == (AW+1)'(DEPTH);
  assign empty     = cnt == '0;
  assign push      = wr_en && !full;
  assign head      = mem[rp];
  assign head_data = head[BITS-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)
        cnt <= cnt + (AW+1)'(1);
      else if (pop && !push)
        cnt <= cnt - (AW+1)'(1);
      if (wr_en && full) ovf <= 1'b1;
    end
  end

  state_t          state;
  state_t          state_d;
  logic [BITS-1:0] tx_sr;
  logic [BITS-1:0] rx_sr;
  logic [BW-1:0]   bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            last_q;
  logic            done;
  logic            ss_d;
  logic            sdo_d;

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    done    = 1'b0;
    ss_d    = ss;
    sdo_d   = sdo;
    unique case (state)
      IDLE: begin
        ss_d  = 1'b1;
        sdo_d = 1'b0;
        if (!empty) state_d = LOAD;
      end
      LOAD: begin
        pop     = 1'b1;
        ss_d    = 1'b0;
        sdo_d   = first_bit(head_data);
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          done = 1'b1;
          if (last_q) begin
            ss_d    = 1'b1;
            sdo_d   = 1'b0;
            state_d = GAP_HI;
          end else if (!empty) begin
            pop   = 1'b1;
            sdo_d = first_bit(head_data);
          end else begin
            sdo_d   = 1'b0;
            state_d = STALL;
          end
        end else begin
          sdo_d = first_bit(tx_sr);
        end
      end
      STALL: begin
        sdo_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          sdo_d   = first_bit(head_data);
          state_d = SHIFT;
        end
      end
      GAP_HI: begin
        ss_d  = 1'b1;
        sdo_d = 1'b0;
        // A queued frame goes straight to LOAD so ss stays high GAP+1.
        if (gap_cnt == '0)
          state_d = empty ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      ss       <= 1'b1;
      sdo      <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_d;
      busy     <= state_d != IDLE;
      ss       <= ss_d;
      sdo      <= sdo_d;
      rx_valid <= done;
      if (pop) begin
        tx_sr   <= tx_adv(head_data);
        last_q  <= head[BITS];
        bit_cnt <= BW'(BITS - 1);
      end else if (state == SHIFT) begin
        tx_sr   <= tx_adv(tx_sr);
        bit_cnt <= bit_cnt - BW'(1);
      end
      if (state == SHIFT) rx_sr <= rx_ins(rx_sr, sdi);
      if (done) rx_data <= rx_ins(rx_sr, sdi);
      if (state_d == GAP_HI && state != GAP_HI)
        gap_cnt <= GW'(GAP - 1);
      else if (state == GAP_HI)
        gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed bench for spi_frame_ctrl.
// Default MSB-first build, DEPTH=4 BITS=8 GAP=2.
module tb_spi_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       full;
  logic       empty;
  logic       busy;
  logic       ss;
  logic       sdo;
  logic       sdi;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       ovf;

  logic [7:0] sdi_word;
  logic [2:0] bit_pos;

  int checks;
  int errors;

  spi_frame_ctrl #(
    .DEPTH(4),
    .BITS (8),
    .GAP  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_last (wr_last),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .ss      (ss),
    .sdo     (sdo),
    .sdi     (sdi),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: presents sdi_word MSB first, one bit per ss-low cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst)
      bit_pos <= 3'd0;
    else if (ss)
      bit_pos <= 3'd0;
    else
      bit_pos <= bit_pos + 3'd1;
  end

  assign sdi = sdi_word[3'd7 - bit_pos];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [7:0] d,
    input logic       l
  );
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = l;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic run_frame(
    output int          hi,
    output int          lo,
    output logic [31:0] bits,
    output int          nrx
  );
    int n;
    hi   = 0;
    lo   = 0;
    bits = '0;
    nrx  = 0;
    n    = 0;
    while (ss === 1'b0 && n < 100) begin
      tick();
      n++;
    end
    while (ss === 1'b1 && n < 100) begin
      hi++;
      tick();
      n++;
    end
    while (n < 100) begin
      if (rx_valid === 1'b1) nrx++;
      if (ss === 1'b1) break;
      lo++;
      bits = {bits[30:0], sdo};
      tick();
      n++;
    end
    if (n >= 100) lo = 0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] b16;
    logic [31:0] fb;
    int bad;
    int hi;
    int lo;
    int nrx;
    int rx_i [2];
    logic [7:0] rx_d [2];

    checks   = 0;
    errors   = 0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    wr_last  = 1'b0;
    sdi_word = 8'h00;
    rst      = 1'b1;
    #1 rst   = 1'b0;
    #1;
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_empty_full", {30'd0, empty, full}, 32'h2);
    chk("rst_busy_ovf", {30'd0, busy, ovf}, 32'h0);
    chk("rst_rx", {23'd0, rx_valid, rx_data}, 32'h0);
    rst = 1'b1;
    tick();

    // Single frame
    sdi_word = 8'hFE;
    push(8'h9F, 1'b1);
    chk("t1_empty", 32'(empty), 32'd0);
    tick();
    chk("t1_load", {30'd0, ss, busy}, 32'h3);
    tick();
    b = '0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], sdo};
      if (ss !== 1'b0) bad++;
      if (rx_valid !== 1'b0) bad++;
      tick();
    end
    chk("t1_sdo", 32'(b), 32'h9F);
    chk("t1_ss_low", 32'(bad), 32'd0);
    chk("t1_end", {30'd0, ss, rx_valid}, 32'h3);
    chk("t1_rx", 32'(rx_data), 32'hFE);
    tick();
    chk("t1_gap", {29'd0, ss, rx_valid, busy}, 32'h5);
    tick();
    chk("t1_idle", {30'd0, ss, busy}, 32'h2);

    // Back-to-back
    sdi_word = 8'h96;
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b1);
    tick();
    b16 = '0;
    bad = 0;
    nrx = 0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        b16 = {b16[14:0], sdo};
        if (ss !== 1'b0) bad++;
      end
      if (rx_valid === 1'b1) begin
        if (nrx < 2) begin
          rx_i[nrx] = i;
          rx_d[nrx] = rx_data;
        end
        nrx++;
      end
      if (i < 16) tick();
    end
    chk("t2_sdo", 32'(b16), 32'hA53C);
    chk("t2_ss_low", 32'(bad), 32'd0);
    chk("t2_nrx", 32'(nrx), 32'd2);
    if (nrx == 2) begin
      chk("t2_rx_pos", 32'(rx_i[1] - rx_i[0]), 32'd8);
      chk("t2_rx0", 32'(rx_d[0]), 32'h96);
      chk("t2_rx1", 32'(rx_d[1]), 32'h96);
    end
    chk("t2_ss_end", 32'(ss), 32'd1);
    wait_idle("t2_idle");

    // Stall
    sdi_word = 8'hFF;
    push(8'h55, 1'b0);
    tick();
    tick();
    b = '0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], sdo};
      if (ss !== 1'b0) bad++;
      tick();
    end
    chk("t3_byte0", 32'(b), 32'h55);
    chk("t3_stall_ent", {30'd0, ss, sdo}, 32'h0);
    chk("t3_rx0", {23'd0, rx_valid, rx_data}, 32'h1FF);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ss !== 1'b0 || sdo !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("t3_stall_hold", 32'(bad), 32'd0);
    push(8'h0F, 1'b1);
    chk("t3_visible", {29'd0, ss, sdo, empty}, 32'h0);
    tick();
    b = '0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], sdo};
      if (ss !== 1'b0) bad++;
      tick();
    end
    chk("t3_byte1", 32'(b), 32'h0F);
    chk("t3_ss_low", 32'(bad), 32'd0);
    chk("t3_end", {30'd0, ss, rx_valid}, 32'h3);
    wait_idle("t3_idle");

    // Full / overflow while a frame is in flight
    sdi_word = 8'h00;
    push(8'hC3, 1'b1);
    tick();
    tick();
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    chk("t4_not_full", {30'd0, full, ovf}, 32'h0);
    push(8'h44, 1'b1);
    chk("t4_full", {30'd0, full, ovf}, 32'h2);
    push(8'hEE, 1'b1);
    chk("t4_ovf", {30'd0, full, ovf}, 32'h3);
    run_frame(hi, lo, fb, nrx);
    chk("t4_gap", 32'(hi), 32'd3);
    chk("t4_len", 32'(lo), 32'd32);
    chk("t4_bits", fb, 32'h11223344);
    chk("t4_nrx", 32'(nrx), 32'd4);
    wait_idle("t4_idle");
    chk("t4_post", {30'd0, empty, ovf}, 32'h3);

    // Frame gap between two single-byte frames
    push(8'h5A, 1'b1);
    push(8'hA5, 1'b1);
    run_frame(hi, lo, fb, nrx);
    chk("t5_f0", fb, 32'h5A);
    chk("t5_f0_len", 32'(lo), 32'd8);
    run_frame(hi, lo, fb, nrx);
    chk("t5_gap", 32'(hi), 32'd3);
    chk("t5_f1", fb, 32'hA5);
    chk("t5_f1_len", 32'(lo), 32'd8);
    wait_idle("t5_idle");

    // Async reset mid-byte
    push(8'hE7, 1'b0);
    push(8'h81, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_pre", {29'd0, ss, empty, ovf}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t6_ss_sdo", {30'd0, ss, sdo}, 32'h2);
    chk("t6_fifo", {30'd0, empty, full}, 32'h2);
    chk("t6_flags", {29'd0, rx_valid, busy, ovf}, 32'h0);
    #2 rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ss !== 1'b1 || sdo !== 1'b0) bad++;
      if (rx_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("t6_quiet", 32'(bad), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
